// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - pixel coordinate, renderer colour and DAC pin bundle for vga_timing_gen
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 10,
  parameter int COLOR_W = 8,
  parameter int FRAME_W = 16
);
  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic               active;
  logic               line_start;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_count;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic               vga_hs;
  logic               vga_vs;
  logic [COLOR_W-1:0] vga_r;
  logic [COLOR_W-1:0] vga_g;
  logic [COLOR_W-1:0] vga_b;
  logic               vga_sync_n;
  logic               vga_blank_n;

  modport master (
    output x, y, active, line_start, frame_start, frame_count,
    output vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_sync_n, vga_blank_n,
    input  pix_r, pix_g, pix_b
  );

  modport slave (
    input  x, y, active, line_start, frame_start, frame_count,
    input  vga_hs, vga_vs, vga_r, vga_g, vga_b, vga_sync_n, vga_blank_n,
    output pix_r, pix_g, pix_b
  );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing sweep with renderer-latency aligned output stage
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int PIPE     = 2,
  parameter int COLOR_W  = 8,
  parameter int FRAME_W  = 16
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master bus
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW = $clog2(H_TOTAL);
  localparam int YW = $clog2(V_TOTAL);

  // Inclusive bounds so a region ending on the last count never overflows XW/YW.
  localparam logic [XW-1:0] H_LAST     = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_LAST = XW'(H_ACTIVE - 1);
  localparam logic [XW-1:0] HS_FIRST   = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] HS_LAST    = XW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [YW-1:0] V_LAST     = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_LAST = YW'(V_ACTIVE - 1);
  localparam logic [YW-1:0] VS_FIRST   = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] VS_LAST    = YW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [XW-1:0]      x_q, x_d;
  logic [YW-1:0]      y_q, y_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               hs_raw, vs_raw, act_raw;
  logic               hs_dly, vs_dly, act_dly;
  logic               vga_hs_q, vga_vs_q, blank_n_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;

  always_comb begin
    x_d     = x_q + 1'b1;
    y_d     = y_q;
    frame_d = frame_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      if (y_q == V_LAST) begin
        y_d     = '0;
        frame_d = frame_q + 1'b1;
      end else begin
        y_d = y_q + 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= '0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= frame_d;
    end
  end

  assign act_raw = (x_q <= H_ACT_LAST) && (y_q <= V_ACT_LAST);
  assign hs_raw  = (x_q >= HS_FIRST) && (x_q <= HS_LAST);
  assign vs_raw  = (y_q >= VS_FIRST) && (y_q <= VS_LAST);

  // Delay sync/blank by the renderer latency so they line up with pix_* on arrival.
  generate
    if (PIPE == 0) begin : g_no_pipe
      assign hs_dly  = hs_raw;
      assign vs_dly  = vs_raw;
      assign act_dly = act_raw;
    end else begin : g_pipe
      logic [PIPE-1:0] hs_sr_q, vs_sr_q, act_sr_q;

      always_ff @(posedge vga_clk) begin
        if (reset) begin
          hs_sr_q  <= '0;
          vs_sr_q  <= '0;
          act_sr_q <= '0;
        end else begin
          hs_sr_q[0]  <= hs_raw;
          vs_sr_q[0]  <= vs_raw;
          act_sr_q[0] <= act_raw;
          for (int i = 1; i < PIPE; i++) begin
            hs_sr_q[i]  <= hs_sr_q[i-1];
            vs_sr_q[i]  <= vs_sr_q[i-1];
            act_sr_q[i] <= act_sr_q[i-1];
          end
        end
      end

      assign hs_dly  = hs_sr_q[PIPE-1];
      assign vs_dly  = vs_sr_q[PIPE-1];
      assign act_dly = act_sr_q[PIPE-1];
    end
  endgenerate

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      vga_hs_q  <= ~HS_POL;
      vga_vs_q  <= ~VS_POL;
      blank_n_q <= 1'b0;
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
    end else begin
      vga_hs_q  <= hs_dly ? HS_POL : ~HS_POL;
      vga_vs_q  <= vs_dly ? VS_POL : ~VS_POL;
      blank_n_q <= act_dly;
      r_q       <= act_dly ? bus.pix_r : '0;
      g_q       <= act_dly ? bus.pix_g : '0;
      b_q       <= act_dly ? bus.pix_b : '0;
    end
  end

  assign bus.x           = x_q;
  assign bus.y           = y_q;
  assign bus.active      = act_raw;
  assign bus.line_start  = (x_q == '0);
  assign bus.frame_start = (x_q == '0) && (y_q == '0);
  assign bus.frame_count = frame_q;
  assign bus.vga_hs      = vga_hs_q;
  assign bus.vga_vs      = vga_vs_q;
  assign bus.vga_blank_n = blank_n_q;
  assign bus.vga_r       = r_q;
  assign bus.vga_g       = g_q;
  assign bus.vga_b       = b_q;
  assign bus.vga_sync_n  = 1'b0;
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen: small 8x6 mode plus default 640x480 mode
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst_s, rst_d;
  int   total = 0;
  int   bad = 0;
  int   k = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.X_W(3), .Y_W(3), .COLOR_W(8), .FRAME_W(2)) s_bus ();
  vga_timing_gen_if #(.X_W(10), .Y_W(10), .COLOR_W(8), .FRAME_W(16)) d_bus ();

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b1), .PIPE(2), .COLOR_W(8), .FRAME_W(2)
  ) u_small (.vga_clk(clk), .reset(rst_s), .bus(s_bus));

  vga_timing_gen #(.PIPE(0)) u_dflt (.vga_clk(clk), .reset(rst_d), .bus(d_bus));

  // Small mode: 8 clocks per line, 6 lines per frame, hs at x=5..6, vs at y=4.
  function automatic int sx(input int n); return n % 8; endfunction
  function automatic int sy(input int n); return (n / 8) % 6; endfunction
  function automatic bit sact(input int n); return (sx(n) < 4) && (sy(n) < 3); endfunction
  function automatic bit shs(input int n); return (sx(n) == 5) || (sx(n) == 6); endfunction
  function automatic bit svs(input int n); return sy(n) == 4; endfunction
  function automatic int spix(input int n); return sx(n) + 16 * sy(n); endfunction

  // Renderer stand-in: colour of the pixel two cycles back, 0xFF outside the picture.
  task automatic step();
    @(posedge clk); #1;
    k++;
    if (k >= 2 && sact(k - 2)) s_bus.pix_r = 8'(spix(k - 2));
    else s_bus.pix_r = 8'hFF;
    s_bus.pix_g = 8'h00;
    s_bus.pix_b = sact(k - 2) ? 8'h3C : 8'hFF;
    d_bus.pix_r = 8'hA5;
    d_bus.pix_g = 8'h5A;
    d_bus.pix_b = 8'hFF;
  endtask

  task automatic test_reset();
    rst_s = 1'b1; rst_d = 1'b1;
    s_bus.pix_r = 8'hFF; s_bus.pix_g = 8'hFF; s_bus.pix_b = 8'hFF;
    d_bus.pix_r = 8'hA5; d_bus.pix_g = 8'h5A; d_bus.pix_b = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    total++; if (s_bus.vga_hs !== 1'b1) begin bad++; $display("FAIL reset_hs: got %b want 1", s_bus.vga_hs); end
    total++; if (s_bus.vga_vs !== 1'b0) begin bad++; $display("FAIL reset_vs: got %b want 0", s_bus.vga_vs); end
    total++; if (s_bus.vga_blank_n !== 1'b0) begin bad++; $display("FAIL reset_blank_n: got %b want 0", s_bus.vga_blank_n); end
    total++; if (s_bus.vga_r !== 8'h00) begin bad++; $display("FAIL reset_r: got %h want 00", s_bus.vga_r); end
    total++; if (s_bus.vga_sync_n !== 1'b0) begin bad++; $display("FAIL reset_sync_n: got %b want 0", s_bus.vga_sync_n); end
    total++; if (s_bus.frame_count !== 2'd0) begin bad++; $display("FAIL reset_frame_count: got %0d want 0", s_bus.frame_count); end
    total++; if (s_bus.x !== 3'd0) begin bad++; $display("FAIL reset_x: got %0d want 0", s_bus.x); end
    total++; if (s_bus.y !== 3'd0) begin bad++; $display("FAIL reset_y: got %0d want 0", s_bus.y); end
    rst_s = 1'b0;
    k = 0;
    total++; if (s_bus.active !== 1'b1) begin bad++; $display("FAIL release_active: got %b want 1", s_bus.active); end
    total++; if (s_bus.line_start !== 1'b1) begin bad++; $display("FAIL release_line_start: got %b want 1", s_bus.line_start); end
    total++; if (s_bus.frame_start !== 1'b1) begin bad++; $display("FAIL release_frame_start: got %b want 1", s_bus.frame_start); end
  endtask

  task automatic test_timing();
    logic e_hs, e_vs, e_bl;
    for (int i = 0; i < 96; i++) begin
      step();
      e_hs = (k >= 3 && shs(k - 3)) ? 1'b0 : 1'b1;
      e_vs = (k >= 3 && svs(k - 3));
      e_bl = (k >= 3 && sact(k - 3));
      total++; if (s_bus.x !== 3'(sx(k))) begin bad++; $display("FAIL timing_x k=%0d: got %0d want %0d", k, s_bus.x, sx(k)); end
      total++; if (s_bus.y !== 3'(sy(k))) begin bad++; $display("FAIL timing_y k=%0d: got %0d want %0d", k, s_bus.y, sy(k)); end
      total++; if (s_bus.active !== sact(k)) begin bad++; $display("FAIL timing_active k=%0d: got %b want %b", k, s_bus.active, sact(k)); end
      total++; if (s_bus.line_start !== (k % 8 == 0)) begin bad++; $display("FAIL timing_line_start k=%0d: got %b", k, s_bus.line_start); end
      total++; if (s_bus.frame_start !== (k % 48 == 0)) begin bad++; $display("FAIL timing_frame_start k=%0d: got %b", k, s_bus.frame_start); end
      total++; if (s_bus.frame_count !== 2'((k / 48) % 4)) begin bad++; $display("FAIL timing_frame_count k=%0d: got %0d want %0d", k, s_bus.frame_count, (k / 48) % 4); end
      total++; if (s_bus.vga_hs !== e_hs) begin bad++; $display("FAIL timing_hs k=%0d: got %b want %b", k, s_bus.vga_hs, e_hs); end
      total++; if (s_bus.vga_vs !== e_vs) begin bad++; $display("FAIL timing_vs k=%0d: got %b want %b", k, s_bus.vga_vs, e_vs); end
      total++; if (s_bus.vga_blank_n !== e_bl) begin bad++; $display("FAIL timing_blank_n k=%0d: got %b want %b", k, s_bus.vga_blank_n, e_bl); end
    end
  endtask

  task automatic test_latency();
    logic       e_bl;
    logic [7:0] e_r, e_b;
    for (int i = 0; i < 48; i++) begin
      step();
      e_bl = (k >= 3 && sact(k - 3));
      e_r  = e_bl ? 8'(spix(k - 3)) : 8'h00;
      e_b  = e_bl ? 8'h3C : 8'h00;
      total++; if (s_bus.vga_r !== e_r) begin bad++; $display("FAIL latency_r k=%0d: got %h want %h", k, s_bus.vga_r, e_r); end
      total++; if (s_bus.vga_b !== e_b) begin bad++; $display("FAIL latency_b k=%0d: got %h want %h", k, s_bus.vga_b, e_b); end
      total++; if (s_bus.vga_sync_n !== 1'b0) begin bad++; $display("FAIL latency_sync_n k=%0d: got %b want 0", k, s_bus.vga_sync_n); end
    end
  endtask

  task automatic test_wrap();
    logic e_vs;
    for (int i = 0; i < 156; i++) begin
      step();
      e_vs = svs(k - 3);
      total++; if (s_bus.frame_count !== 2'((k / 48) % 4)) begin bad++; $display("FAIL wrap_frame_count k=%0d: got %0d want %0d", k, s_bus.frame_count, (k / 48) % 4); end
      total++; if (s_bus.vga_vs !== e_vs) begin bad++; $display("FAIL wrap_vs k=%0d: got %b want %b", k, s_bus.vga_vs, e_vs); end
    end
  endtask

  task automatic test_mid_reset();
    logic       e_hs, e_bl;
    logic [7:0] e_r;
    for (int i = 0; i < 48 && (k % 48) != 19; i++) step();
    total++; if (s_bus.x !== 3'd3 || s_bus.y !== 3'd2) begin bad++; $display("FAIL midrst_pos: got x=%0d y=%0d want x=3 y=2", s_bus.x, s_bus.y); end
    rst_s = 1'b1;
    @(posedge clk); #1;
    rst_s = 1'b0;
    k = 0;
    s_bus.pix_r = 8'hFF; s_bus.pix_b = 8'hFF;
    total++; if (s_bus.x !== 3'd0 || s_bus.y !== 3'd0) begin bad++; $display("FAIL midrst_restart: got x=%0d y=%0d want 0 0", s_bus.x, s_bus.y); end
    total++; if (s_bus.frame_start !== 1'b1) begin bad++; $display("FAIL midrst_frame_start: got %b want 1", s_bus.frame_start); end
    total++; if (s_bus.frame_count !== 2'd0) begin bad++; $display("FAIL midrst_frame_count: got %0d want 0", s_bus.frame_count); end
    total++; if (s_bus.vga_blank_n !== 1'b0) begin bad++; $display("FAIL midrst_blank_n0: got %b want 0", s_bus.vga_blank_n); end
    total++; if (s_bus.vga_r !== 8'h00) begin bad++; $display("FAIL midrst_r0: got %h want 00", s_bus.vga_r); end
    for (int i = 0; i < 10; i++) begin
      step();
      e_hs = (k >= 3 && shs(k - 3)) ? 1'b0 : 1'b1;
      e_bl = (k >= 3 && sact(k - 3));
      e_r  = e_bl ? 8'(spix(k - 3)) : 8'h00;
      total++; if (s_bus.x !== 3'(sx(k))) begin bad++; $display("FAIL midrst_x k=%0d: got %0d want %0d", k, s_bus.x, sx(k)); end
      total++; if (s_bus.vga_blank_n !== e_bl) begin bad++; $display("FAIL midrst_blank_n k=%0d: got %b want %b", k, s_bus.vga_blank_n, e_bl); end
      total++; if (s_bus.vga_r !== e_r) begin bad++; $display("FAIL midrst_r k=%0d: got %h want %h", k, s_bus.vga_r, e_r); end
      total++; if (s_bus.vga_hs !== e_hs) begin bad++; $display("FAIL midrst_hs k=%0d: got %b want %b", k, s_bus.vga_hs, e_hs); end
    end
  endtask

  task automatic test_default();
    int         first_ls, hs_low, bl_cnt, xm;
    logic       e_bl, e_hs;
    logic [7:0] e_r;
    first_ls = -1; hs_low = 0; bl_cnt = 0;
    rst_d = 1'b0;
    total++; if (d_bus.x !== 10'd0 || d_bus.y !== 10'd0) begin bad++; $display("FAIL dflt_release_xy: got x=%0d y=%0d want 0 0", d_bus.x, d_bus.y); end
    total++; if (d_bus.frame_start !== 1'b1) begin bad++; $display("FAIL dflt_release_frame_start: got %b want 1", d_bus.frame_start); end
    for (int c = 1; c <= 1600; c++) begin
      step();
      xm   = (c - 1) % 800;
      e_bl = (xm < 640);
      e_hs = (xm >= 656 && xm <= 751) ? 1'b0 : 1'b1;
      e_r  = e_bl ? 8'hA5 : 8'h00;
      if (d_bus.line_start === 1'b1 && first_ls < 0) first_ls = c;
      if (c <= 800 && d_bus.vga_hs === 1'b0) hs_low++;
      if (c <= 800 && d_bus.vga_blank_n === 1'b1) bl_cnt++;
      total++; if (d_bus.vga_hs !== e_hs) begin bad++; $display("FAIL dflt_hs c=%0d: got %b want %b", c, d_bus.vga_hs, e_hs); end
      total++; if (d_bus.vga_vs !== 1'b1) begin bad++; $display("FAIL dflt_vs c=%0d: got %b want 1", c, d_bus.vga_vs); end
      total++; if (d_bus.vga_blank_n !== e_bl) begin bad++; $display("FAIL dflt_blank_n c=%0d: got %b want %b", c, d_bus.vga_blank_n, e_bl); end
      total++; if (d_bus.vga_r !== e_r) begin bad++; $display("FAIL dflt_r c=%0d: got %h want %h", c, d_bus.vga_r, e_r); end
      if (c == 800) begin
        total++; if (d_bus.x !== 10'd0 || d_bus.y !== 10'd1) begin bad++; $display("FAIL dflt_line1: got x=%0d y=%0d want 0 1", d_bus.x, d_bus.y); end
      end
    end
    total++; if (first_ls != 800) begin bad++; $display("FAIL dflt_line_period: got %0d want 800", first_ls); end
    total++; if (hs_low != 96) begin bad++; $display("FAIL dflt_hs_width: got %0d want 96", hs_low); end
    total++; if (bl_cnt != 640) begin bad++; $display("FAIL dflt_visible_width: got %0d want 640", bl_cnt); end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_latency();
    test_wrap();
    test_mid_reset();
    test_default();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and output stage, the successor to the fixed-mode vga block fed by the PLL pixel clock. It sweeps horizontal and vertical counters for any resolution and timing, with configurable sync polarities. It publishes pixel coordinates to a downstream renderer and accepts that renderer's RGB after a configurable pipeline latency. It re-aligns sync and blank with the returned pixels and drives the DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, asserted level of vga_hs (0 = active-low)
VS_POL, 0, asserted level of vga_vs
PIPE, 2, renderer latency in cycles from x/y to pix_*; legal range 0..15
COLOR_W, 8, bits per colour channel
FRAME_W, 16, frame counter width

Ports:
vga_clk  in  1  pixel clock; all logic on rising edge
reset  in  1  synchronous, active-high
x  out  clog2(H_TOTAL)  current horizontal count; H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP
y  out  clog2(V_TOTAL)  current vertical count; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP
active  out  1  x<H_ACTIVE && y<V_ACTIVE
line_start  out  1  one-cycle pulse when x==0
frame_start  out  1  one-cycle pulse when x==0 && y==0
frame_count  out  FRAME_W  number of completed frames; wraps
pix_r, pix_g, pix_b  in  COLOR_W each  renderer colour for the x/y presented PIPE cycles earlier
vga_hs  out  1  horizontal sync
vga_vs  out  1  vertical sync
vga_r, vga_g, vga_b  out  COLOR_W each  DAC colour
vga_sync_n  out  1  held constant 0 (no sync-on-green)
vga_blank_n  out  1  high during the visible region

Behaviour:
- Counters: x increments every cycle. At H_TOTAL-1 it wraps to 0 and y increments. y wraps from V_TOTAL-1 to 0. x/y/active/line_start/frame_start are combinational decodes of the counter registers, so they are valid in the same cycle.
- Horizontal regions: active for 0..H_ACTIVE-1. Front porch follows, then sync for [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], then back porch. Vertical regions are identical, in lines. hs_raw asserts in the sync range, and vs_raw likewise.
- frame_count increments on the cycle the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0). FRAME_W-bit wrap.
- Alignment: hs_raw, vs_raw and active enter a PIPE-stage shift register. The outputs are registered once more. Total latency is PIPE+1 cycles.
- Output timing: in cycle k, vga_hs/vga_vs/vga_blank_n reflect counter state at k-PIPE-1. vga_r/g/b equal pix_* sampled at k-1, gated to zero when the delayed active is 0.
- Polarity: vga_hs = hs_delayed ? HS_POL : ~HS_POL. vga_vs likewise with VS_POL.
- Reset, while held and on the first edge:
  - counters go to (0,0) and frame_count to 0;
  - all delay stages load the inactive state (no sync, not active);
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL, vga_blank_n = 0, RGB = 0, vga_sync_n = 0.
- After reset: the first cycle with reset low shows x=0, y=0, active=1, line_start=1, frame_start=1. The delayed outputs stay blank and inactive until the pipeline fills (PIPE+1 cycles).
- Reset mid-frame: the same synchronous behaviour applies. The next cycle restarts at (0,0), and pixels already in flight are discarded (the shift register is cleared).
- PIPE=0: pix_* correspond to the current x/y. The outputs are still one register stage late.
- pix_* outside the active region are ignored.

Test Plan:
- Reset values: hold reset 3 cycles with HS_POL=0, VS_POL=1 -> vga_hs=1, vga_vs=0, blank_n=0, RGB=0, sync_n=0, frame_count=0, x=y=0.
- Small mode H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), PIPE=2 -> raw hs asserted at x=5,6. vga_hs goes low 3 cycles later. blank_n high for 4 of 8 cycles on lines 0..2. frame_start period is 48 cycles.
- Latency: renderer drives pix_r = x + 16*y delayed by PIPE -> vga_r matches the expected value for each visible pixel. vga_r=0 whenever blank_n=0, even with pix_r=0xFF.
- Wrap: run 2^FRAME_W+1 frames with FRAME_W=2 -> frame_count sequence 0,1,2,3,0,1. vs is asserted exactly at y=4 each frame.
- Mid-frame reset: assert reset at x=3, y=2 for 1 cycle -> next cycle x=0, y=0, frame_start=1. The outputs stay blank for PIPE+1 cycles, with no stale pixel emitted.
- Default 640x480 with PIPE=0 -> line period 800, frame period 420000 cycles. hs low width 96 and vs low width 2 lines (1600 cycles).
